fg_tach: RTL and testbench
==========================

FG_TACH -- requirements
Module: fg_tach

Interface
REQ-001 Parameter DIV_N, default 6, number of accepted FG edges per FG_FB period; even, 2..64.
REQ-002 Parameter CNT_W, default 24, width of the period counter and PER.
REQ-003 Parameter GLITCH, default 1000, minimum clocks between accepted rising edges (10 us at 100 MHz).
REQ-004 Parameter TMO, default 2_000_000, stall timeout in clocks (20 ms); GLITCH < TMO < 2^CNT_W-1.
REQ-005 CLK1  input  1  system clock, 100 MHz.
REQ-006 RESET_N  input  1  reset; one clock, asynchronous, active-low.
REQ-007 FG_IN  input  1  raw motor FG/tach pulse, asynchronous, nominal 360 Hz.
REQ-008 EN  input  1  measurement enable, synchronous to CLK1.
REQ-009 FG_FB  output  1  FG_IN divided by DIV_N, 50% duty, registered; feeds the fractional PWM loop as fgFb.
REQ-010 PER  output  CNT_W  clocks between the last two accepted FG_IN rising edges.
REQ-011 PER_VLD  output  1  one-clock strobe; PER updated this cycle.
REQ-012 STALL  output  1  high while no accepted edge has arrived within TMO clocks.

Function
REQ-013 FG_IN SHALL pass through a 2-flop synchronizer; a rising edge is sync2=1 with the previous sync2=0, registered (edge strobe).
REQ-014 Interval counter cnt SHALL clear to 0 on an accepted edge, otherwise increment by 1 per clock, saturating at 2^CNT_W-1.
REQ-015 An edge strobe SHALL be accepted only when EN=1 and (state=IDLE or cnt+1 >= GLITCH); rejected edges change no state, counter or output.
REQ-016 States: IDLE, ACQ, RUN, STL; reset state IDLE.
REQ-017 IDLE: cnt held 0, div_cnt held 0; first accepted edge -> ACQ.
REQ-018 ACQ: accepted edge -> RUN with PER <= cnt+1 and PER_VLD=1.
REQ-019 RUN: each accepted edge -> PER <= cnt+1 and PER_VLD=1, stay RUN.
REQ-020 ACQ or RUN: cnt+1 = TMO with no accepted edge that cycle -> STL, STALL=1; an accepted edge in the same cycle wins.
REQ-021 STL: accepted edge -> ACQ, STALL=0, no PER_VLD, PER holds.
REQ-022 EN=0 in any state -> IDLE next clock; cnt, div_cnt, FG_FB, STALL, PER_VLD cleared; PER holds.
REQ-023 div_cnt (0..DIV_N-1) SHALL increment on each accepted edge in every state, wrapping DIV_N-1 -> 0.
REQ-024 FG_FB SHALL be registered as (div_cnt >= DIV_N/2), updating on the same clock as div_cnt.
REQ-025 For an edge strobe registered on clock k, the acceptance outputs (PER, PER_VLD, FG_FB, STALL clear) SHALL update on clock k+1; total latency from the FG_IN sampling edge is 3 clocks.
REQ-026 PER SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-027 RESET_N=0 SHALL immediately force the state to IDLE, synchronizer flops, cnt, div_cnt, PER, PER_VLD, FG_FB and STALL to 0, independent of CLK1.
REQ-028 After RESET_N release, the first accepted edge SHALL produce no PER_VLD.

Verification
REQ-029 Reset, EN=1, CLK1-aligned FG_IN with period 277_778 clocks -> no PER_VLD on rise 1; on rise 2 and every later rise, PER_VLD with PER=277_778, arriving 3 clocks after the sampling edge.
REQ-030 Same stimulus, 12 rises -> FG_FB rises on rises 3 and 9 and falls on rise 6, giving period 1_666_668 clocks, high 833_334 clocks.
REQ-031 5-clock pulse starting 500 clocks after an accepted edge -> no PER_VLD and no FG_FB change; next real rise gives PER equal to the full interval.
REQ-032 Stop FG_IN after 4 rises -> STALL=1 exactly TMO clocks after the last acceptance; the next rise gives STALL=0 and no PER_VLD; the following rise gives PER_VLD with the true interval.
REQ-033 EN=0 mid-RUN with FG_FB=1 -> FG_FB=0 and state IDLE next clock, PER unchanged; EN=1 again -> first rise gives no PER_VLD.
REQ-034 RESET_N low mid-RUN, asynchronous to CLK1 -> all outputs 0 before the next CLK1 edge.

Source files
------------

// File: rtl/fg_tach.sv
// rtl/fg_tach.sv - FG tach period measurement, divided feedback and stall detection
module fg_tach #(
  parameter int DIV_N  = 6,
  parameter int CNT_W  = 24,
  parameter int GLITCH = 1000,
  parameter int TMO    = 2_000_000
) (
  input  logic             CLK1,
  input  logic             RESET_N,
  input  logic             FG_IN,
  input  logic             EN,
  output logic             FG_FB,
  output logic [CNT_W-1:0] PER,
  output logic             PER_VLD,
  output logic             STALL
);

  localparam int DW = (DIV_N > 2) ? $clog2(DIV_N) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV_N - 1);
  localparam logic [DW-1:0]  DIV_HALF = DW'(DIV_N / 2);
  localparam logic [CNT_W:0] GLITCH_C = (CNT_W + 1)'(GLITCH);
  localparam logic [CNT_W:0] TMO_C    = (CNT_W + 1)'(TMO);
  localparam logic [CNT_W:0] ONE_C    = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ACQ, RUN, STL} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q, edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic             fb_q, fb_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             vld_q, vld_d;
  logic             stall_q, stall_d;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic [DW-1:0]    div_nxt;
  logic             accept;
  logic             timeout;

  // Synchronize FG_IN and register a one-clock rising-edge strobe
  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= FG_IN;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // cnt+1 saturates so a long stall can never wrap into a short bogus period
  assign cnt_inc = {1'b0, cnt_q} + ONE_C;
  assign cnt_sat = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
  assign div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  assign accept  = EN & edge_q & ((state_q == IDLE) | (cnt_inc >= GLITCH_C));
  assign timeout = ((state_q == ACQ) | (state_q == RUN)) & (cnt_inc == TMO_C);

  // Next-state and output decode; an accepted edge takes priority over timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_sat;
    div_d   = div_q;
    fb_d    = fb_q;
    per_d   = per_q;
    vld_d   = 1'b0;
    stall_d = stall_q;
    if (!EN) begin
      state_d = IDLE;
      cnt_d   = '0;
      div_d   = '0;
      fb_d    = 1'b0;
      stall_d = 1'b0;
    end else if (accept) begin
      cnt_d   = '0;
      div_d   = div_nxt;
      fb_d    = (div_nxt >= DIV_HALF);
      stall_d = 1'b0;
      case (state_q)
        IDLE:    state_d = ACQ;
        ACQ,
        RUN: begin
          state_d = RUN;
          per_d   = cnt_sat;
          vld_d   = 1'b1;
        end
        default: state_d = ACQ;
      endcase
    end else if (timeout) begin
      state_d = STL;
      stall_d = 1'b1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      fb_q    <= 1'b0;
      per_q   <= '0;
      vld_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      fb_q    <= fb_d;
      per_q   <= per_d;
      vld_q   <= vld_d;
      stall_q <= stall_d;
    end
  end

  assign FG_FB   = fb_q;
  assign PER     = per_q;
  assign PER_VLD = vld_q;
  assign STALL   = stall_q;

endmodule

// File: tb/tb_fg_tach.sv
// tb/tb_fg_tach.sv - self-checking bench for fg_tach against an event-level model
module tb_fg_tach;

  localparam int DIV_N  = 6;
  localparam int CNT_W  = 16;
  localparam int GLITCH = 600;
  localparam int TMO    = 5000;
  localparam int P      = 1000;

  logic             CLK1 = 1'b0;
  logic             RESET_N = 1'b0;
  logic             FG_IN = 1'b0;
  logic             EN = 1'b0;
  logic             FG_FB;
  logic [CNT_W-1:0] PER;
  logic             PER_VLD;
  logic             STALL;

  int cyc = 0;
  int n_eval = 0;
  int n_fail = 0;

  // Model: timing of accepted rises (in FG_IN sample cycles) and derived outputs
  bit               m_active, m_primed, m_stalled;
  int               m_last, m_div;
  logic [CNT_W-1:0] m_per;
  int               vld_exp = 0;
  int               vld_seen = 0;
  int               fb_rise[$];
  int               fb_fall[$];
  logic             prev_fb = 1'b0;

  fg_tach #(.DIV_N(DIV_N), .CNT_W(CNT_W), .GLITCH(GLITCH), .TMO(TMO)) dut (
    .CLK1(CLK1), .RESET_N(RESET_N), .FG_IN(FG_IN), .EN(EN),
    .FG_FB(FG_FB), .PER(PER), .PER_VLD(PER_VLD), .STALL(STALL)
  );

  always #5 CLK1 = ~CLK1;

  always @(posedge CLK1) cyc <= cyc + 1;

  always @(negedge CLK1) begin
    if (PER_VLD === 1'b1) vld_seen++;
    if (FG_FB === 1'b1 && prev_fb === 1'b0) fb_rise.push_back(cyc);
    if (FG_FB === 1'b0 && prev_fb === 1'b1) fb_fall.push_back(cyc);
    prev_fb = FG_FB;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge CLK1);
      #1;
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_primed  = 1'b0;
    m_stalled = 1'b0;
    m_div     = 0;
    m_last    = 0;
  endtask

  // Drive a rise sampled on cycle s, held high hi (>=5) cycles, and check its outcome
  task automatic do_rise(input int s, input int hi, input string tag);
    bit e_vld;
    int iv;
    wait_cyc(s - 1);
    @(negedge CLK1);
    FG_IN = 1'b1;
    iv = s - m_last;
    e_vld = 1'b0;
    if (m_active && !m_stalled && iv > TMO) begin
      m_stalled = 1'b1;
      m_primed  = 1'b0;
    end
    if (!m_active || iv >= GLITCH) begin
      e_vld = m_primed;
      if (e_vld) begin
        m_per = (iv > (1 << CNT_W) - 1) ? '1 : iv[CNT_W-1:0];
        vld_exp++;
      end
      m_primed  = 1'b1;
      m_active  = 1'b1;
      m_stalled = 1'b0;
      m_last    = s;
      m_div     = (m_div + 1) % DIV_N;
    end
    wait_cyc(s + 2);
    chk({tag, ".early_vld"}, 32'(PER_VLD), 32'(0));
    wait_cyc(s + 3);
    chk({tag, ".vld"}, 32'(PER_VLD), 32'(e_vld));
    chk({tag, ".per"}, 32'(PER), 32'(m_per));
    chk({tag, ".fb"}, 32'(FG_FB), 32'(m_div >= DIV_N / 2));
    chk({tag, ".stall"}, 32'(STALL), 32'(m_stalled));
    wait_cyc(s + 4);
    chk({tag, ".vld_off"}, 32'(PER_VLD), 32'(0));
    wait_cyc(s + hi - 1);
    @(negedge CLK1);
    FG_IN = 1'b0;
  endtask

  initial begin
    int s;
    int t;
    model_reset();
    m_per = '0;
    RESET_N = 1'b0;
    EN = 1'b1;
    repeat (3) @(posedge CLK1);
    #1;
    chk("reset.per", 32'(PER), 32'(0));
    chk("reset.vld", 32'(PER_VLD), 32'(0));
    chk("reset.fb", 32'(FG_FB), 32'(0));
    chk("reset.stall", 32'(STALL), 32'(0));
    @(negedge CLK1);
    RESET_N = 1'b1;

    // Fixed period: PER and divided-feedback waveform
    s = cyc + 20;
    for (int i = 0; i < 12; i++) begin
      do_rise(s, 8, "base");
      s += P;
    end
    chk("fb.rise_count", 32'(fb_rise.size() >= 2), 32'(1));
    if (fb_rise.size() >= 2 && fb_fall.size() >= 1) begin
      chk("fb.period", 32'(fb_rise[1] - fb_rise[0]), 32'(6 * P));
      chk("fb.high", 32'(fb_fall[0] - fb_rise[0]), 32'(3 * P));
    end

    // Random intervals
    for (int i = 0; i < 6; i++) begin
      do_rise(m_last + int'($urandom_range(700, 2000)), 8, "rand");
    end

    // Boundaries: exactly GLITCH accepted, exactly TMO accepted without stall
    do_rise(m_last + GLITCH, 8, "glitch_eq");
    do_rise(m_last + TMO, 8, "tmo_eq");

    // Short pulses inside the glitch window are rejected
    do_rise(m_last + 300, 5, "glitch300");
    do_rise(m_last + GLITCH - 1, 5, "glitch599");
    do_rise(m_last + 1200, 8, "after_glitch");

    // Stall: STALL rises exactly TMO clocks after the last acceptance
    t = m_last + 3 + TMO;
    wait_cyc(t - 1);
    chk("stall.before", 32'(STALL), 32'(0));
    wait_cyc(t);
    chk("stall.at", 32'(STALL), 32'(1));
    do_rise(m_last + TMO + 500, 8, "stall_clear");
    do_rise(m_last + 900, 8, "stall_next");

    // Disable while FG_FB is high
    while (m_div < DIV_N / 2) do_rise(m_last + 800, 8, "to_fb_high");
    chk("en.fb_before", 32'(FG_FB), 32'(1));
    wait_cyc(m_last + 50);
    @(negedge CLK1);
    EN = 1'b0;
    wait_cyc(cyc + 1);
    chk("en.fb", 32'(FG_FB), 32'(0));
    chk("en.stall", 32'(STALL), 32'(0));
    chk("en.vld", 32'(PER_VLD), 32'(0));
    chk("en.per", 32'(PER), 32'(m_per));
    model_reset();
    repeat (20) @(posedge CLK1);
    @(negedge CLK1);
    EN = 1'b1;
    do_rise(cyc + 30, 8, "en_first");
    do_rise(m_last + 1000, 8, "en_second");
    do_rise(m_last + 1100, 8, "en_third");

    // Asynchronous reset between clock edges
    wait_cyc(cyc + 10);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("areset.per", 32'(PER), 32'(0));
    chk("areset.vld", 32'(PER_VLD), 32'(0));
    chk("areset.fb", 32'(FG_FB), 32'(0));
    chk("areset.stall", 32'(STALL), 32'(0));
    model_reset();
    m_per = '0;
    repeat (2) @(posedge CLK1);
    @(negedge CLK1);
    RESET_N = 1'b1;
    do_rise(cyc + 30, 8, "post_reset_first");
    do_rise(m_last + 777, 8, "post_reset_second");

    repeat (10) @(posedge CLK1);
    #1;
    chk("vld_count", 32'(vld_seen), 32'(vld_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
